// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle for the nibble-serial adder controller.
// The master side launches additions; the slave side is the controller itself.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    logic                   start;
    logic                   clear;
    logic [4*NIBBLES-1:0]   a;
    logic [4*NIBBLES-1:0]   b;
    logic                   cin;
    logic                   busy;
    logic                   done;
    logic [4*NIBBLES-1:0]   sum;
    logic                   cout;
    logic                   ovf;

    modport master (
        output start, clear, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, clear, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder built by sequencing an external combinational 4-bit ripple-carry
// adder one nibble per cycle, carrying between nibbles through a register.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus,
    output logic [3:0]           rca_a,
    output logic [3:0]           rca_b,
    output logic                 rca_cin,
    input  logic [3:0]           rca_sum,
    input  logic [3:0]           rca_cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    logic [1:0]    state;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          carry;
    logic [IW-1:0] idx;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;

    // NOTE: every register here is a plain flop with an async clear; sequential
    // state is assigned with <= so all updates see the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (bus.clear) begin
            state  <= S_IDLE;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op_a   <= bus.a;
                        op_b   <= bus.b;
                        carry  <= bus.cin;
                        idx    <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        state  <= S_RUN;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (idx == IW'(n)) sum_q[4*n +: 4] <= rca_sum;
                    end
                    carry <= rca_cout[3];
                    if (idx == LAST_IDX) begin
                        cout_q <= rca_cout[3];
                        ovf_q  <= rca_cout[2] ^ rca_cout[3];
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The adder sees zeros outside RUN so it stays quiet between operations.
    always_comb begin
        rca_a   = 4'h0;
        rca_b   = 4'h0;
        rca_cin = 1'b0;
        if (state == S_RUN) begin
            rca_a   = 4'(op_a >> {idx, 2'b00});
            rca_b   = 4'(op_b >> {idx, 2'b00});
            rca_cin = carry;
        end
    end

    assign bus.busy = (state == S_RUN);
    assign bus.done = (state == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
